// File: rtl/arilla_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : arilla_bus_pkg
// Description : Shared types and constants for arilla bus responders.
// Revision    : 1.0 - initial release
// ============================================================================
package arilla_bus_pkg;

    localparam int ARILLA_BUS__LANES = 4;
    localparam int WAIT_CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } responder_state_e;

    // Word-index width for a byte window; never below one bit.
    function automatic int index_width(input int unsigned size_bytes);
        return ($clog2(size_bytes) > 2) ? ($clog2(size_bytes) - 2) : 1;
    endfunction

endpackage : arilla_bus_pkg
`default_nettype wire

// File: rtl/arilla_bus_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface   : arilla_bus_if
// Description : Word-oriented request/complete bus between initiator and responders.
// Revision    : 1.0 - initial release
// ============================================================================
interface arilla_bus_if;
    import arilla_bus_pkg::*;

    logic [31:0]                  address;
    logic [31:0]                  data_write;
    logic [ARILLA_BUS__LANES-1:0] byte_enable;
    logic                         read;
    logic                         write;
    logic [31:0]                  data_read;
    logic                         intercept;
    logic                         complete;
    logic                         fault;

    modport responder (
        input  address, data_write, byte_enable, read, write,
        output data_read, intercept, complete, fault
    );

    modport initiator (
        output address, data_write, byte_enable, read, write,
        input  data_read, intercept, complete, fault
    );

endinterface : arilla_bus_if
`default_nettype wire

// File: rtl/sp_ram_be.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sp_ram_be
// Description : Single-port 4-lane byte-enabled synchronous RAM, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be
    import arilla_bus_pkg::*;
#(
    parameter int Depth     = 16384,
    parameter     InitFile  = "",
    localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [AddrWidth-1:0]         addr,
    input  logic [ARILLA_BUS__LANES-1:0] be,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] r_mem [0:Depth-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < ARILLA_BUS__LANES; i++) begin
                    if (be[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : sp_ram_be
`default_nettype wire

// File: rtl/arilla_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arilla_ram_responder
// Description : Byte-enabled RAM target on arilla_bus_if with configurable wait.
//               Define ARILLA_RAM_RESPONDER_WP_EN to add the wp write-protect port.
// Revision    : 1.0 - initial release
// ============================================================================
module arilla_ram_responder
    import arilla_bus_pkg::*;
#(
    parameter logic [31:0] BaseAddress  = 32'h0000_0000,
    parameter int unsigned SizeBytes    = 65536,
    parameter int unsigned WaitStates   = 0,
    parameter              InitFile     = ""
`ifdef ARILLA_RAM_RESPONDER_WP_EN
    , parameter int unsigned ProtectBytes = 0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    arilla_bus_if.responder  bus_interface
`ifdef ARILLA_RAM_RESPONDER_WP_EN
    , input logic            wp
`endif
);

    localparam int          IDX_W      = index_width(SizeBytes);
    localparam int          DEPTH      = 1 << IDX_W;
    localparam logic [31:0] c_win_mask = ~(32'(SizeBytes) - 32'd1);
    localparam logic [WAIT_CNT_W-1:0] c_wait_init = WAIT_CNT_W'(WaitStates);

    responder_state_e               r_state;
    responder_state_e               w_state_next;
    logic [WAIT_CNT_W-1:0]          r_count;
    logic [IDX_W-1:0]               r_index;
    logic [ARILLA_BUS__LANES-1:0]   r_be;
    logic [31:0]                    r_wdata;
    logic                           r_read;
    logic                           r_write;
    logic                           r_fault;

    logic                           w_req;
    logic                           w_hit;
    logic                           w_capture;
    logic                           w_protect;
    logic                           w_fault_in;
    logic [IDX_W-1:0]               w_bus_index;
    logic [1:0]                     w_unused_bits;

    logic                           w_ram_rd;
    logic                           w_ram_wr;
    logic [IDX_W-1:0]               w_ram_addr;
    logic [31:0]                    w_ram_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_req     = bus_interface.read || bus_interface.write;
    assign w_hit     = (bus_interface.address & c_win_mask) == BaseAddress;
    assign w_capture = (r_state == IDLE) && w_hit && w_req;
    assign w_unused_bits = bus_interface.address[1:0];

    generate
        if (SizeBytes > 4) begin : g_idx_wide
            assign w_bus_index = bus_interface.address[IDX_W+1:2];
        end else begin : g_idx_single
            assign w_bus_index = '0;
        end
    endgenerate

`ifdef ARILLA_RAM_RESPONDER_WP_EN
    assign w_protect = bus_interface.write && wp &&
                       ((bus_interface.address - BaseAddress) < 32'(ProtectBytes));
`else
    assign w_protect = 1'b0;
`endif

    assign w_fault_in = (bus_interface.read && bus_interface.write) || w_protect;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_state_next = (WaitStates == 0) ? DONE : WAIT;
            WAIT:    if (r_count == WAIT_CNT_W'(1)) w_state_next = DONE;
            DONE:    w_state_next = DRAIN;
            DRAIN:   if (!w_req) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_interface.intercept = w_hit && w_req;
        bus_interface.complete  = (r_state == DONE);
        bus_interface.fault     = (r_state == DONE) && r_fault;
        bus_interface.data_read = ((r_state == DONE) && r_read && !r_fault) ? w_ram_rdata : '0;
    end

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_index <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_fault <= 1'b0;
        end else if (w_capture) begin
            r_count <= c_wait_init;
            r_index <= w_bus_index;
            r_be    <= bus_interface.byte_enable;
            r_wdata <= bus_interface.data_write;
            r_read  <= bus_interface.read;
            r_write <= bus_interface.write;
            r_fault <= w_fault_in;
        end else if (r_state == WAIT) begin
            r_count <= r_count - WAIT_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // RAM access: the registered read is launched on the edge that enters
    // DONE so the word is on data_read during the complete cycle; writes
    // commit on the edge leaving DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_rd   = 1'b0;
        w_ram_wr   = (r_state == DONE) && r_write && !r_fault;
        w_ram_addr = r_index;
        if (r_state == IDLE) begin
            w_ram_addr = w_bus_index;
            w_ram_rd   = (w_state_next == DONE) && bus_interface.read && !w_fault_in;
        end else if (r_state == WAIT) begin
            w_ram_rd   = (w_state_next == DONE) && r_read && !r_fault;
        end
    end

    sp_ram_be #(
        .Depth    (DEPTH),
        .InitFile (InitFile)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_rd || w_ram_wr),
        .we    (w_ram_wr),
        .addr  (w_ram_addr),
        .be    (r_be),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

endmodule : arilla_ram_responder
`default_nettype wire
